// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and pointer arithmetic for the four-way round-robin mux arbiter.
package mux_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Priority pointer advances past the last winner; 3 wraps to 0 through the 2-bit width.
    function automatic sel_t ptr_inc(input sel_t p);
        return p + sel_t'(1);
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux2.sv
// Team 4:1 payload multiplexer, selected by a 2-bit index.
module MUX2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] d3_i,
    input  logic [1:0]       sel_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            2'd3:    y_o = d3_i;
            default: y_o = d0_i;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a single registered output slot.
// Handshake: a requester transfers when its req_ready bit is high (it need not wait for
// ready); the output transfers when out_valid && out_ready are both high on a rising edge.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [WIDTH-1:0]     req_data0,
    input  logic [WIDTH-1:0]     req_data1,
    input  logic [WIDTH-1:0]     req_data2,
    input  logic [WIDTH-1:0]     req_data3,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    sel_t             out_sel_q,   out_sel_d;
    sel_t             ptr_q,       ptr_d;

    logic             load;
    logic             found;
    sel_t             winner;
    sel_t             idx;
    logic [WIDTH-1:0] mux_data;

    assign load = !out_valid_q || out_ready;

    // Search starts at the pointer and wraps naturally through the 2-bit index.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + sel_t'(k);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Held low during reset even though the empty register would otherwise offer a load.
    always_comb begin
        req_ready = '0;
        if (rstn && load && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    MUX2 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .d0_i (req_data0),
        .d1_i (req_data1),
        .d2_i (req_data2),
        .d3_i (req_data3),
        .sel_i(winner),
        .y_o  (mux_data)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = mux_data;
                out_sel_d   = winner;
                ptr_d       = ptr_inc(winner);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
